id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: i_reset  in  1  synchronous reset, active-high, sampled on the rising edge of clk.
REQ-003 SHALL have ID-side inputs (width): i_id_valid 1, i_id_pc 32, i_id_rs1_data 32, i_id_rs2_data 32, i_id_imm 32, i_id_rs1 5, i_id_rs2 5, i_id_rd 5, i_id_rs1_used 1, i_id_rs2_used 1, i_id_reg_wen 1, i_id_mem_ren 1, i_id_mem_wen 1, i_id_wb_sel 2, i_id_alu_op 4, i_id_br 1.
REQ-004 SHALL have control inputs: i_hold 1 (freeze ID/EX), i_flush 1 (squash ID instruction, branch redirect).
REQ-005 SHALL have writeback snoop inputs: i_wb_wen 1, i_wb_rd 5, i_wb_data 32 (same values driving the register file write port).
REQ-006 SHALL have registered outputs o_ex_<field> mirroring every REQ-003 field (same widths).
REQ-007 SHALL have outputs o_stall 1 (combinational, freeze PC and IF/ID) and o_lu_cnt 16 (registered load-use stall count).

Function
REQ-008 Next-state priority per cycle SHALL be: i_reset > i_flush > i_hold > load-use bubble > normal load.
REQ-009 Normal load SHALL copy every ID field into the EX register on the clock edge (latency 1 cycle).
REQ-010 Load-use hazard lu SHALL be: o_ex_valid & o_ex_mem_ren & o_ex_rd!=0 & i_id_valid & ((i_id_rs1_used & i_id_rs1==o_ex_rd) | (i_id_rs2_used & i_id_rs2==o_ex_rd)).
REQ-011 A bubble SHALL set o_ex_valid, o_ex_reg_wen, o_ex_mem_ren, o_ex_mem_wen, o_ex_br to 0; other fields don't-care but SHALL be zeroed.
REQ-012 On lu with i_flush=0, i_hold=0: EX SHALL load a bubble and o_stall SHALL be 1 in that cycle.
REQ-013 On i_flush=1 (not reset): EX SHALL load a bubble regardless of i_hold or lu; o_stall SHALL be 0.
REQ-014 On i_hold=1, i_flush=0: EX register SHALL keep its value except per REQ-015; o_stall SHALL be 1.
REQ-015 While holding, if i_wb_wen=1, i_wb_rd!=0 and i_wb_rd equals a held source index whose used bit is 1, that held operand (o_ex_rs1_data/o_ex_rs2_data) SHALL be replaced by i_wb_data; both may update in the same cycle.
REQ-016 o_stall SHALL equal ~i_flush & (i_hold | lu), independent of i_reset.
REQ-017 o_lu_cnt SHALL increment by 1 on each edge where REQ-012 bubble insertion occurs, saturating at 16'hFFFF (no wrap).
REQ-018 Snoop (REQ-015) SHALL NOT apply on normal load; same-cycle write/read bypass is provided by the register file.
REQ-019 rd==0 with mem_ren SHALL never trigger lu; x0 snoop writes SHALL be ignored.

Reset
REQ-020 On i_reset=1 at a clock edge, all o_ex_* SHALL become 0 and o_lu_cnt SHALL become 0, overriding flush, hold and lu.
REQ-021 Reset mid-hold or mid-stall SHALL discard the held instruction; first edge after reset deasserts performs a normal load.
REQ-022 No state SHALL change asynchronously; reset asserted between edges has no effect until the next edge.

Verification
REQ-023 Load then dependent add: EX holds lw x5 (mem_ren=1, rd=5, valid=1), ID add rs1=5 used -> o_stall=1, next EX valid=0, o_lu_cnt 0->1; following cycle add loads with valid=1.
REQ-024 Flush vs stall: same as REQ-023 plus i_flush=1 -> o_stall=0, next EX bubble, o_lu_cnt unchanged.
REQ-025 Hold snoop: EX holds rs2=7 used, rs2_data=0x11; i_hold=1, i_wb_wen=1, i_wb_rd=7, i_wb_data=0xDEADBEEF -> o_ex_rs2_data=0xDEADBEEF next cycle, all other fields unchanged; with i_wb_rd=0 -> no change.
REQ-026 x0 load: EX lw rd=0 mem_ren=1, ID rs1=0 used -> o_stall=0, normal load.
REQ-027 Counter saturation: preload o_lu_cnt to 0xFFFE, apply 3 load-use bubbles -> 0xFFFF, 0xFFFF, 0xFFFF.
REQ-028 Reset during hold: EX valid=1 held, assert i_reset one edge -> all o_ex_*=0, o_lu_cnt=0; release with ID valid pc=0x100 -> o_ex_pc=0x100, o_ex_valid=1 next edge.

Source files
------------

// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline register bus: ID-side fields, pipeline control, writeback
// snoop, and the registered EX-side view with stall and load-use statistics.
interface id_ex_if;
  logic        i_id_valid;
  logic [31:0] i_id_pc;
  logic [31:0] i_id_rs1_data;
  logic [31:0] i_id_rs2_data;
  logic [31:0] i_id_imm;
  logic [4:0]  i_id_rs1;
  logic [4:0]  i_id_rs2;
  logic [4:0]  i_id_rd;
  logic        i_id_rs1_used;
  logic        i_id_rs2_used;
  logic        i_id_reg_wen;
  logic        i_id_mem_ren;
  logic        i_id_mem_wen;
  logic [1:0]  i_id_wb_sel;
  logic [3:0]  i_id_alu_op;
  logic        i_id_br;

  logic        i_hold;
  logic        i_flush;

  logic        i_wb_wen;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;

  logic        o_ex_valid;
  logic [31:0] o_ex_pc;
  logic [31:0] o_ex_rs1_data;
  logic [31:0] o_ex_rs2_data;
  logic [31:0] o_ex_imm;
  logic [4:0]  o_ex_rs1;
  logic [4:0]  o_ex_rs2;
  logic [4:0]  o_ex_rd;
  logic        o_ex_rs1_used;
  logic        o_ex_rs2_used;
  logic        o_ex_reg_wen;
  logic        o_ex_mem_ren;
  logic        o_ex_mem_wen;
  logic [1:0]  o_ex_wb_sel;
  logic [3:0]  o_ex_alu_op;
  logic        o_ex_br;

  logic        o_stall;
  logic [15:0] o_lu_cnt;

  modport master (
    output i_id_valid, i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_imm,
           i_id_rs1, i_id_rs2, i_id_rd, i_id_rs1_used, i_id_rs2_used,
           i_id_reg_wen, i_id_mem_ren, i_id_mem_wen, i_id_wb_sel,
           i_id_alu_op, i_id_br, i_hold, i_flush, i_wb_wen, i_wb_rd,
           i_wb_data,
    input  o_ex_valid, o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm,
           o_ex_rs1, o_ex_rs2, o_ex_rd, o_ex_rs1_used, o_ex_rs2_used,
           o_ex_reg_wen, o_ex_mem_ren, o_ex_mem_wen, o_ex_wb_sel,
           o_ex_alu_op, o_ex_br, o_stall, o_lu_cnt
  );

  modport slave (
    input  i_id_valid, i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_imm,
           i_id_rs1, i_id_rs2, i_id_rd, i_id_rs1_used, i_id_rs2_used,
           i_id_reg_wen, i_id_mem_ren, i_id_mem_wen, i_id_wb_sel,
           i_id_alu_op, i_id_br, i_hold, i_flush, i_wb_wen, i_wb_rd,
           i_wb_data,
    output o_ex_valid, o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm,
           o_ex_rs1, o_ex_rs2, o_ex_rd, o_ex_rs1_used, o_ex_rs2_used,
           o_ex_reg_wen, o_ex_mem_ren, o_ex_mem_wen, o_ex_wb_sel,
           o_ex_alu_op, o_ex_br, o_stall, o_lu_cnt
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash,
// hold with writeback snoop on the held operands, and a saturating count
// of inserted load-use bubbles.
module id_ex_reg (
  input logic    clk,
  input logic    i_reset,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_used;
    logic        rs2_used;
    logic        reg_wen;
    logic        mem_ren;
    logic        mem_wen;
    logic [1:0]  wb_sel;
    logic [3:0]  alu_op;
    logic        br;
  } ex_t;

  ex_t         ex_q;
  ex_t         ex_d;
  ex_t         id_in;
  logic [15:0] lu_cnt_q;
  logic [15:0] lu_cnt_d;
  logic        lu;
  logic        snoop_ok;

  // Gather the ID-side fields into one record.
  always_comb begin
    id_in          = '0;
    id_in.valid    = bus.i_id_valid;
    id_in.pc       = bus.i_id_pc;
    id_in.rs1_data = bus.i_id_rs1_data;
    id_in.rs2_data = bus.i_id_rs2_data;
    id_in.imm      = bus.i_id_imm;
    id_in.rs1      = bus.i_id_rs1;
    id_in.rs2      = bus.i_id_rs2;
    id_in.rd       = bus.i_id_rd;
    id_in.rs1_used = bus.i_id_rs1_used;
    id_in.rs2_used = bus.i_id_rs2_used;
    id_in.reg_wen  = bus.i_id_reg_wen;
    id_in.mem_ren  = bus.i_id_mem_ren;
    id_in.mem_wen  = bus.i_id_mem_wen;
    id_in.wb_sel   = bus.i_id_wb_sel;
    id_in.alu_op   = bus.i_id_alu_op;
    id_in.br       = bus.i_id_br;
  end

  // A load in EX whose destination an ID source needs; x0 never hazards.
  assign lu = ex_q.valid & ex_q.mem_ren & (ex_q.rd != 5'd0) & bus.i_id_valid &
              ((bus.i_id_rs1_used & (bus.i_id_rs1 == ex_q.rd)) |
               (bus.i_id_rs2_used & (bus.i_id_rs2 == ex_q.rd)));

  // Flush redirects fetch anyway, so it never needs the front end frozen.
  assign bus.o_stall = ~bus.i_flush & (bus.i_hold | lu);

  assign snoop_ok = bus.i_wb_wen & (bus.i_wb_rd != 5'd0);

  // Next EX contents and bubble count: flush > hold > load-use > load.
  always_comb begin
    ex_d     = ex_q;
    lu_cnt_d = lu_cnt_q;
    if (bus.i_flush) begin
      ex_d = '0;
    end else if (bus.i_hold) begin
      // A held instruction would otherwise miss a writeback that retires
      // while it waits, since it already read the register file.
      if (snoop_ok && ex_q.rs1_used && (ex_q.rs1 == bus.i_wb_rd))
        ex_d.rs1_data = bus.i_wb_data;
      if (snoop_ok && ex_q.rs2_used && (ex_q.rs2 == bus.i_wb_rd))
        ex_d.rs2_data = bus.i_wb_data;
    end else if (lu) begin
      ex_d = '0;
      if (lu_cnt_q != 16'hFFFF)
        lu_cnt_d = lu_cnt_q + 16'd1;
    end else begin
      ex_d = id_in;
    end
  end

  // EX register and bubble counter, synchronous reset overriding all.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      ex_q     <= '0;
      lu_cnt_q <= '0;
    end else begin
      ex_q     <= ex_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  assign bus.o_ex_valid    = ex_q.valid;
  assign bus.o_ex_pc       = ex_q.pc;
  assign bus.o_ex_rs1_data = ex_q.rs1_data;
  assign bus.o_ex_rs2_data = ex_q.rs2_data;
  assign bus.o_ex_imm      = ex_q.imm;
  assign bus.o_ex_rs1      = ex_q.rs1;
  assign bus.o_ex_rs2      = ex_q.rs2;
  assign bus.o_ex_rd       = ex_q.rd;
  assign bus.o_ex_rs1_used = ex_q.rs1_used;
  assign bus.o_ex_rs2_used = ex_q.rs2_used;
  assign bus.o_ex_reg_wen  = ex_q.reg_wen;
  assign bus.o_ex_mem_ren  = ex_q.mem_ren;
  assign bus.o_ex_mem_wen  = ex_q.mem_wen;
  assign bus.o_ex_wb_sel   = ex_q.wb_sel;
  assign bus.o_ex_alu_op   = ex_q.alu_op;
  assign bus.o_ex_br       = ex_q.br;
  assign bus.o_lu_cnt      = lu_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: ordered vector table with a scoreboard queue, then
// counter saturation and between-edge reset sequences.
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_used;
    logic        rs2_used;
    logic        reg_wen;
    logic        mem_ren;
    logic        mem_wen;
    logic [1:0]  wb_sel;
    logic [3:0]  alu_op;
    logic        br;
  } ex_t;

  typedef struct {
    string       name;
    logic        rst;
    logic        flush;
    logic        hold;
    ex_t         id;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exp_stall;
    ex_t         exp_ex;
    logic [15:0] exp_cnt;
  } vec_t;

  typedef struct {
    string       name;
    ex_t         ex;
    logic [15:0] cnt;
  } sb_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t tbl[$];
  sb_t  sbq[$];

  id_ex_if bus ();

  id_ex_reg dut (
    .clk     (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ex_t ins(input logic [31:0] pc, input logic [4:0] rs1,
                              input logic u1, input logic [4:0] rs2,
                              input logic u2, input logic [4:0] rd,
                              input logic mr, input logic [31:0] d1,
                              input logic [31:0] d2);
    ex_t e;
    e          = '0;
    e.valid    = 1'b1;
    e.pc       = pc;
    e.rs1      = rs1;
    e.rs1_used = u1;
    e.rs2      = rs2;
    e.rs2_used = u2;
    e.rd       = rd;
    e.mem_ren  = mr;
    e.rs1_data = d1;
    e.rs2_data = d2;
    e.imm      = pc ^ 32'h0F0F_0000;
    e.reg_wen  = 1'b1;
    e.mem_wen  = pc[3];
    e.wb_sel   = mr ? 2'd1 : 2'd2;
    e.alu_op   = pc[5:2];
    e.br       = pc[2];
    return e;
  endfunction

  function automatic vec_t mk(input string nm, input logic r, input logic f,
                              input logic h, input ex_t id, input logic we,
                              input logic [4:0] wrd, input logic [31:0] wd,
                              input logic es, input ex_t ee,
                              input logic [15:0] ec);
    vec_t v;
    v.name = nm; v.rst = r; v.flush = f; v.hold = h; v.id = id;
    v.wb_wen = we; v.wb_rd = wrd; v.wb_data = wd;
    v.exp_stall = es; v.exp_ex = ee; v.exp_cnt = ec;
    return v;
  endfunction

  function automatic ex_t sample_ex();
    ex_t e;
    e.valid    = bus.o_ex_valid;
    e.pc       = bus.o_ex_pc;
    e.rs1_data = bus.o_ex_rs1_data;
    e.rs2_data = bus.o_ex_rs2_data;
    e.imm      = bus.o_ex_imm;
    e.rs1      = bus.o_ex_rs1;
    e.rs2      = bus.o_ex_rs2;
    e.rd       = bus.o_ex_rd;
    e.rs1_used = bus.o_ex_rs1_used;
    e.rs2_used = bus.o_ex_rs2_used;
    e.reg_wen  = bus.o_ex_reg_wen;
    e.mem_ren  = bus.o_ex_mem_ren;
    e.mem_wen  = bus.o_ex_mem_wen;
    e.wb_sel   = bus.o_ex_wb_sel;
    e.alu_op   = bus.o_ex_alu_op;
    e.br       = bus.o_ex_br;
    return e;
  endfunction

  task automatic drive(input vec_t v);
    rst               = v.rst;
    bus.i_flush       = v.flush;
    bus.i_hold        = v.hold;
    bus.i_wb_wen      = v.wb_wen;
    bus.i_wb_rd       = v.wb_rd;
    bus.i_wb_data     = v.wb_data;
    bus.i_id_valid    = v.id.valid;
    bus.i_id_pc       = v.id.pc;
    bus.i_id_rs1_data = v.id.rs1_data;
    bus.i_id_rs2_data = v.id.rs2_data;
    bus.i_id_imm      = v.id.imm;
    bus.i_id_rs1      = v.id.rs1;
    bus.i_id_rs2      = v.id.rs2;
    bus.i_id_rd       = v.id.rd;
    bus.i_id_rs1_used = v.id.rs1_used;
    bus.i_id_rs2_used = v.id.rs2_used;
    bus.i_id_reg_wen  = v.id.reg_wen;
    bus.i_id_mem_ren  = v.id.mem_ren;
    bus.i_id_mem_wen  = v.id.mem_wen;
    bus.i_id_wb_sel   = v.id.wb_sel;
    bus.i_id_alu_op   = v.id.alu_op;
    bus.i_id_br       = v.id.br;
  endtask

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_sb();
    sb_t s;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      s = sbq.pop_front();
      chk({s.name, ".ex"}, 256'(sample_ex()), 256'(s.ex));
      chk({s.name, ".cnt"}, 256'(bus.o_lu_cnt), 256'(s.cnt));
    end
  endtask

  task automatic apply(input vec_t v);
    sb_t s;
    @(negedge clk);
    drive(v);
    #1;
    chk({v.name, ".stall"}, 256'(bus.o_stall), 256'(v.exp_stall));
    s.name = v.name; s.ex = v.exp_ex; s.cnt = v.exp_cnt;
    sbq.push_back(s);
    @(posedge clk);
    #1;
    check_sb();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ex_t z, nop, lw5, add, sw, sw_a, sw_b, lw0, use0, dual, dual_s;
    ex_t nu, nu_s, rs2d, nod, inv, p100;
    vec_t tmp;

    total = 0;
    bad   = 0;
    z     = '0;
    nop   = '0;
    lw5   = ins(32'h40, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 32'h1000, 32'h0);
    add   = ins(32'h44, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b0, 32'h55, 32'h66);
    sw    = ins(32'h48, 5'd3, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 32'h2000, 32'h11);
    sw_a  = sw;   sw_a.rs2_data = 32'hDEADBEEF;
    sw_b  = sw_a; sw_b.rs1_data = 32'h33;
    lw0   = ins(32'h4c, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 32'h3000, 32'h0);
    use0  = ins(32'h50, 5'd0, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0, 32'h0, 32'h0);
    dual  = ins(32'h54, 5'd9, 1'b1, 5'd9, 1'b1, 5'd10, 1'b0, 32'ha, 32'hb);
    dual_s = dual; dual_s.rs1_data = 32'h12345678; dual_s.rs2_data = 32'h12345678;
    nu    = ins(32'h58, 5'd10, 1'b0, 5'd10, 1'b1, 5'd11, 1'b0, 32'hc, 32'hd);
    nu_s  = nu; nu_s.rs2_data = 32'h77;
    rs2d  = ins(32'h5c, 5'd1, 1'b1, 5'd5, 1'b1, 5'd12, 1'b0, 32'h1, 32'h2);
    nod   = ins(32'h60, 5'd5, 1'b0, 5'd6, 1'b1, 5'd13, 1'b0, 32'h3, 32'h4);
    inv   = add; inv.valid = 1'b0;
    p100  = ins(32'h100, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b0, 32'h0, 32'h0);

    tmp = mk("init", 1, 0, 0, nop, 0, 0, 0, 0, z, 0);
    drive(tmp);

    //        name               rst fl hd id    we rd  data           stall exp_ex cnt
    tbl.push_back(mk("reset",          1, 0, 0, nop,  0, 0,  32'h0,        0, z,      0));
    tbl.push_back(mk("load_lw",        0, 0, 0, lw5,  0, 0,  32'h0,        0, lw5,    0));
    tbl.push_back(mk("lu_rs1",         0, 0, 0, add,  0, 0,  32'h0,        1, z,      1));
    tbl.push_back(mk("after_bubble",   0, 0, 0, add,  0, 0,  32'h0,        0, add,    1));
    tbl.push_back(mk("lw_b",           0, 0, 0, lw5,  0, 0,  32'h0,        0, lw5,    1));
    tbl.push_back(mk("flush_lu",       0, 1, 0, add,  0, 0,  32'h0,        0, z,      1));
    tbl.push_back(mk("lw_c",           0, 0, 0, lw5,  0, 0,  32'h0,        0, lw5,    1));
    tbl.push_back(mk("flush_hold_lu",  0, 1, 1, add,  0, 0,  32'h0,        0, z,      1));
    tbl.push_back(mk("load_sw",        0, 0, 0, sw,   0, 0,  32'h0,        0, sw,     1));
    tbl.push_back(mk("snoop_rs2",      0, 0, 1, add,  1, 7,  32'hDEADBEEF, 1, sw_a,   1));
    tbl.push_back(mk("snoop_x0",       0, 0, 1, add,  1, 0,  32'hCAFEF00D, 1, sw_a,   1));
    tbl.push_back(mk("snoop_rs1",      0, 0, 1, add,  1, 3,  32'h33,       1, sw_b,   1));
    tbl.push_back(mk("snoop_nowen",    0, 0, 1, add,  0, 7,  32'h99,       1, sw_b,   1));
    tbl.push_back(mk("load_no_snoop",  0, 0, 0, add,  1, 5,  32'h77,       0, add,    1));
    tbl.push_back(mk("load_lw0",       0, 0, 0, lw0,  0, 0,  32'h0,        0, lw0,    1));
    tbl.push_back(mk("x0_no_lu",       0, 0, 0, use0, 0, 0,  32'h0,        0, use0,   1));
    tbl.push_back(mk("snoop_x0_used",  0, 0, 1, nop,  1, 0,  32'hBAD,      1, use0,   1));
    tbl.push_back(mk("load_dual",      0, 0, 0, dual, 0, 0,  32'h0,        0, dual,   1));
    tbl.push_back(mk("snoop_both",     0, 0, 1, nop,  1, 9,  32'h12345678, 1, dual_s, 1));
    tbl.push_back(mk("load_nu",        0, 0, 0, nu,   0, 0,  32'h0,        0, nu,     1));
    tbl.push_back(mk("snoop_used_gate",0, 0, 1, nop,  1, 10, 32'h77,       1, nu_s,   1));
    tbl.push_back(mk("lw_d",           0, 0, 0, lw5,  0, 0,  32'h0,        0, lw5,    1));
    tbl.push_back(mk("lu_rs2",         0, 0, 0, rs2d, 0, 0,  32'h0,        1, z,      2));
    tbl.push_back(mk("lw_e",           0, 0, 0, lw5,  0, 0,  32'h0,        0, lw5,    2));
    tbl.push_back(mk("no_lu_unused",   0, 0, 0, nod,  0, 0,  32'h0,        0, nod,    2));
    tbl.push_back(mk("lw_f",           0, 0, 0, lw5,  0, 0,  32'h0,        0, lw5,    2));
    tbl.push_back(mk("no_lu_invalid",  0, 0, 0, inv,  0, 0,  32'h0,        0, inv,    2));
    tbl.push_back(mk("lw_g",           0, 0, 0, lw5,  0, 0,  32'h0,        0, lw5,    2));
    tbl.push_back(mk("hold_over_lu",   0, 0, 1, add,  0, 0,  32'h0,        1, lw5,    2));
    tbl.push_back(mk("lu_after_hold",  0, 0, 0, add,  0, 0,  32'h0,        1, z,      3));
    tbl.push_back(mk("lw_h",           0, 0, 0, lw5,  0, 0,  32'h0,        0, lw5,    3));
    tbl.push_back(mk("hold_lw",        0, 0, 1, add,  0, 0,  32'h0,        1, lw5,    3));
    tbl.push_back(mk("reset_in_hold",  1, 0, 1, add,  0, 0,  32'h0,        1, z,      0));
    tbl.push_back(mk("after_reset",    0, 0, 0, p100, 0, 0,  32'h0,        0, p100,   0));
    tbl.push_back(mk("lw_i",           0, 0, 0, lw5,  0, 0,  32'h0,        0, lw5,    0));
    tbl.push_back(mk("reset_over_lu",  1, 0, 0, add,  0, 0,  32'h0,        1, z,      0));
    tbl.push_back(mk("post_reset_add", 0, 0, 0, add,  0, 0,  32'h0,        0, add,    0));

    foreach (tbl[i]) apply(tbl[i]);

    // Counter saturation from a preloaded 0xFFFE.
    @(negedge clk);
    drive(mk("sat_pre", 0, 0, 0, lw5, 0, 0, 0, 0, lw5, 16'hFFFE));
    force dut.lu_cnt_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.lu_cnt_q;
    chk("sat_pre.cnt", 256'(bus.o_lu_cnt), 256'(16'hFFFE));
    chk("sat_pre.ex", 256'(sample_ex()), 256'(lw5));
    for (int k = 0; k < 3; k++) begin
      if (k > 0) apply(mk("sat_lw", 0, 0, 0, lw5, 0, 0, 0, 0, lw5, 16'hFFFF));
      apply(mk("sat_lu", 0, 0, 0, add, 0, 0, 0, 1, z, 16'hFFFF));
    end

    // Reset pulsed between edges must leave state untouched.
    apply(mk("async_pre", 0, 0, 0, lw5, 0, 0, 0, 0, lw5, 16'hFFFF));
    @(negedge clk);
    drive(mk("async_rst", 0, 0, 1, add, 0, 0, 0, 1, lw5, 16'hFFFF));
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("async_rst.ex", 256'(sample_ex()), 256'(lw5));
    chk("async_rst.cnt", 256'(bus.o_lu_cnt), 256'(16'hFFFF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
